// File: rtl/sdrd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdrd_pkg
// Description : Shared constants and helpers for the SPI-mode SD card
//               responder: command indices, frame/block geometry, R1 bit
//               positions, state encoding and the serial CRC16 step.
// Revision    : 1.0 - initial release
// ============================================================================
package sdrd_pkg;

    // Command indices decoded by the card
    localparam logic [5:0] c_cmd_go_idle     = 6'd0;
    localparam logic [5:0] c_cmd_send_op     = 6'd1;
    localparam logic [5:0] c_cmd_read_single = 6'd17;

    // Frame and block geometry
    localparam int c_frame_len  = 48;
    localparam int c_block_bits = 512;
    localparam int c_crc16_bits = 16;

    // R1 flag positions
    localparam int c_r1_idle_bit    = 0;
    localparam int c_r1_illegal_bit = 2;
    localparam int c_r1_crc_err_bit = 3;

    // Fixed byte values
    localparam logic [7:0]  c_data_token = 8'hFE;
    localparam logic [7:0]  c_cmd0_crc   = 8'h95;
    localparam logic [15:0] c_crc16_poly = 16'h1021;

    // Card state encoding
    localparam logic [2:0] c_st_rx_cmd   = 3'd0;
    localparam logic [2:0] c_st_gap      = 3'd1;
    localparam logic [2:0] c_st_tx_r1    = 3'd2;
    localparam logic [2:0] c_st_wait_mem = 3'd3;
    localparam logic [2:0] c_st_tx_token = 3'd4;
    localparam logic [2:0] c_st_tx_data  = 3'd5;
    localparam logic [2:0] c_st_tx_crc   = 3'd6;

    // Assemble an R1 byte from its three flags
    function automatic logic [7:0] r1_make(input logic crc_err,
                                           input logic illegal,
                                           input logic idle);
        logic [7:0] r;
        r                   = '0;
        r[c_r1_crc_err_bit] = crc_err;
        r[c_r1_illegal_bit] = illegal;
        r[c_r1_idle_bit]    = idle;
        return r;
    endfunction

    // One serial step of CRC16 (x^16 + x^12 + x^5 + 1), MSB-first input
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic        din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? c_crc16_poly : 16'h0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdrd_crc16.sv
`default_nettype none
// ============================================================================
// Module      : sdrd_crc16
// Description : Serial CRC16 accumulator for the data block.
//   clk    in   clock
//   rst    in   synchronous active-high reset
//   i_clr  in   clear accumulator to 0x0000 (wins over i_en)
//   i_en   in   absorb i_din this cycle
//   i_din  in   serial data bit
//   o_crc  out  current CRC value
// Revision    : 1.0 - initial release
// ============================================================================
module sdrd_crc16
    import sdrd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_din,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= '0;
        end else if (i_clr) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= crc16_step(r_crc, i_din);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sdrd_spi_card.sv
`default_nettype none
// ============================================================================
// Module      : sdrd_spi_card
// Description : SPI-mode SD card responder for the read path. Receives
//               48-bit command frames, answers R1, and for CMD17 fetches a
//               block from a backing store and streams token, data and CRC16.
//   CLK        in   clock (host SCLK)
//   RST        in   synchronous active-high reset
//   CS         in   chip select, active low
//   DI         in   host-to-card serial data
//   DO         out  card-to-host serial data, idles high
//   RD_REQ     out  block fetch request
//   RD_ADR     out  CMD17 argument
//   RD_ACK     in   store acknowledge, RD_DATA valid with it
//   RD_DATA    in   block contents, bit 511 sent first
//   CARD_READY out  initialization complete
//   BUSY       out  card not in command-receive state
// Revision    : 1.0 - initial release
// ============================================================================
module sdrd_spi_card
    import sdrd_pkg::*;
#(
    parameter int N_CR      = 2,
    parameter int INIT_BUSY = 3
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CS,
    input  logic         DI,
    output logic         DO,
    output logic         RD_REQ,
    output logic [31:0]  RD_ADR,
    input  logic         RD_ACK,
    input  logic [511:0] RD_DATA,
    output logic         CARD_READY,
    output logic         BUSY
);

    localparam int c_rx_bits = c_frame_len - 2;

    logic [2:0]             r_state;
    logic                   r_rx_active;
    logic [c_rx_bits-2:0]   r_shift;
    logic [8:0]             r_cnt;
    logic                   r_idle;
    logic [7:0]             r_busy_cnt;
    logic [7:0]             r_r1;
    logic                   r_rd_go;
    logic [15:0]            r_sh;
    logic [c_block_bits-1:0] r_data;

    logic [c_rx_bits-1:0]   w_frame;
    logic [5:0]             w_cmd;
    logic [31:0]            w_arg;
    logic [7:0]             w_crc_byte;
    logic [7:0]             w_r1;
    logic                   w_idle_nxt;
    logic [7:0]             w_busy_nxt;
    logic                   w_rd_go;
    logic                   w_crc_clr;
    logic                   w_crc_en;
    logic [15:0]            w_crc;

    // Frame bits 45:0 as they stand in the cycle the last bit arrives
    assign w_frame    = {r_shift, DI};
    assign w_cmd      = w_frame[45:40];
    assign w_arg      = w_frame[39:8];
    assign w_crc_byte = w_frame[7:0];

    always_comb begin
        w_r1       = r1_make(1'b0, 1'b1, r_idle);
        w_idle_nxt = r_idle;
        w_busy_nxt = r_busy_cnt;
        w_rd_go    = 1'b0;
        case (w_cmd)
            c_cmd_go_idle: begin
                if (w_crc_byte == c_cmd0_crc) begin
                    w_idle_nxt = 1'b1;
                    w_busy_nxt = 8'(INIT_BUSY);
                    w_r1       = r1_make(1'b0, 1'b0, 1'b1);
                end else begin
                    w_r1 = r1_make(1'b1, 1'b0, r_idle);
                end
            end
            c_cmd_send_op: begin
                if (r_busy_cnt != 8'd0) begin
                    w_busy_nxt = r_busy_cnt - 8'd1;
                    w_r1       = r1_make(1'b0, 1'b0, 1'b1);
                end else begin
                    w_idle_nxt = 1'b0;
                    w_r1       = r1_make(1'b0, 1'b0, 1'b0);
                end
            end
            c_cmd_read_single: begin
                if (r_idle) begin
                    w_r1 = r1_make(1'b0, 1'b1, 1'b1);
                end else begin
                    w_r1    = r1_make(1'b0, 1'b0, 1'b0);
                    w_rd_go = 1'b1;
                end
            end
            default: begin
                w_r1 = r1_make(1'b0, 1'b1, r_idle);
            end
        endcase
    end

    // CRC covers exactly the 512 data bits: the first one leaves with the
    // last token edge, the rest during TX_DATA while bits remain.
    assign w_crc_clr = !CS && (r_state == c_st_wait_mem) && RD_ACK;
    assign w_crc_en  = !CS && (((r_state == c_st_tx_token) && (r_cnt == 9'd0)) ||
                               ((r_state == c_st_tx_data)  && (r_cnt != 9'd0)));

    sdrd_crc16 u_crc16 (
        .clk   (CLK),
        .rst   (RST),
        .i_clr (w_crc_clr),
        .i_en  (w_crc_en),
        .i_din (r_data[c_block_bits-1]),
        .o_crc (w_crc)
    );

    // r_cnt counts bits still to emit after the one DO carries now; the
    // edge that finds it at zero moves on to the next phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= c_st_rx_cmd;
            r_rx_active <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_idle      <= 1'b1;
            r_busy_cnt  <= 8'(INIT_BUSY);
            r_r1        <= '0;
            r_rd_go     <= 1'b0;
            r_sh        <= '0;
            r_data      <= '0;
            DO          <= 1'b1;
            RD_REQ      <= 1'b0;
            RD_ADR      <= '0;
        end else if (CS) begin
            // Deselect aborts any transfer; init progress is kept
            r_state     <= c_st_rx_cmd;
            r_rx_active <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            DO          <= 1'b1;
            RD_REQ      <= 1'b0;
        end else begin
            case (r_state)
                c_st_rx_cmd: begin
                    DO <= 1'b1;
                    if (!r_rx_active) begin
                        // First 1 on DI is frame bit 46
                        if (DI) begin
                            r_rx_active <= 1'b1;
                            r_cnt       <= 9'(c_rx_bits);
                        end
                    end else begin
                        r_shift <= w_frame[c_rx_bits-2:0];
                        r_cnt   <= r_cnt - 9'd1;
                        if (r_cnt == 9'd1) begin
                            r_rx_active <= 1'b0;
                            r_shift     <= '0;
                            r_idle      <= w_idle_nxt;
                            r_busy_cnt  <= w_busy_nxt;
                            r_r1        <= w_r1;
                            r_rd_go     <= w_rd_go;
                            if (w_rd_go) begin
                                RD_ADR <= w_arg;
                            end
                            r_cnt   <= 9'(N_CR);
                            r_state <= c_st_gap;
                        end
                    end
                end
                c_st_gap: begin
                    if (r_cnt == 9'd0) begin
                        DO      <= r_r1[7];
                        r_sh    <= {r_r1[6:0], 9'h000};
                        r_cnt   <= 9'd7;
                        r_state <= c_st_tx_r1;
                    end else begin
                        DO    <= 1'b1;
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                c_st_tx_r1: begin
                    if (r_cnt == 9'd0) begin
                        DO <= 1'b1;
                        if (r_rd_go) begin
                            RD_REQ  <= 1'b1;
                            r_state <= c_st_wait_mem;
                        end else begin
                            r_state <= c_st_rx_cmd;
                        end
                    end else begin
                        DO    <= r_sh[15];
                        r_sh  <= {r_sh[14:0], 1'b0};
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                c_st_wait_mem: begin
                    DO <= 1'b1;
                    if (RD_ACK) begin
                        RD_REQ  <= 1'b0;
                        r_data  <= RD_DATA;
                        DO      <= c_data_token[7];
                        r_sh    <= {c_data_token[6:0], 9'h000};
                        r_cnt   <= 9'd7;
                        r_state <= c_st_tx_token;
                    end
                end
                c_st_tx_token: begin
                    if (r_cnt == 9'd0) begin
                        DO      <= r_data[c_block_bits-1];
                        r_data  <= {r_data[c_block_bits-2:0], 1'b0};
                        r_cnt   <= 9'(c_block_bits - 1);
                        r_state <= c_st_tx_data;
                    end else begin
                        DO    <= r_sh[15];
                        r_sh  <= {r_sh[14:0], 1'b0};
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                c_st_tx_data: begin
                    if (r_cnt == 9'd0) begin
                        DO      <= w_crc[15];
                        r_sh    <= {w_crc[14:0], 1'b0};
                        r_cnt   <= 9'(c_crc16_bits - 1);
                        r_state <= c_st_tx_crc;
                    end else begin
                        DO     <= r_data[c_block_bits-1];
                        r_data <= {r_data[c_block_bits-2:0], 1'b0};
                        r_cnt  <= r_cnt - 9'd1;
                    end
                end
                c_st_tx_crc: begin
                    if (r_cnt == 9'd0) begin
                        DO      <= 1'b1;
                        r_state <= c_st_rx_cmd;
                    end else begin
                        DO    <= r_sh[15];
                        r_sh  <= {r_sh[14:0], 1'b0};
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                default: begin
                    DO      <= 1'b1;
                    RD_REQ  <= 1'b0;
                    r_state <= c_st_rx_cmd;
                end
            endcase
        end
    end

    assign BUSY       = (r_state != c_st_rx_cmd);
    assign CARD_READY = !r_idle;

endmodule
`default_nettype wire

// File: tb/tb_sdrd_spi_card.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdrd_spi_card
// Description : Directed self-checking bench for sdrd_spi_card.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdrd_spi_card;

    localparam int N_CR      = 2;
    localparam int INIT_BUSY = 3;

    logic         CLK;
    logic         RST;
    logic         CS;
    logic         DI;
    logic         DO;
    logic         RD_REQ;
    logic [31:0]  RD_ADR;
    logic         RD_ACK;
    logic [511:0] RD_DATA;
    logic         CARD_READY;
    logic         BUSY;

    int n_total;
    int n_bad;

    sdrd_spi_card #(
        .N_CR      (N_CR),
        .INIT_BUSY (INIT_BUSY)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CS         (CS),
        .DI         (DI),
        .DO         (DO),
        .RD_REQ     (RD_REQ),
        .RD_ADR     (RD_ADR),
        .RD_ACK     (RD_ACK),
        .RD_DATA    (RD_DATA),
        .CARD_READY (CARD_READY),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference CRC16, poly 0x1021, init 0, MSB first
    function automatic logic [15:0] crc_model(input logic [511:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int i = 511; i >= 0; i--) begin
            fb = d[i] ^ c[15];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Returns just after the edge that samples frame bit 0 (cycle t)
    task automatic send_frame(input logic [5:0] cmd, input logic [31:0] arg, input logic [7:0] crcb);
        logic [47:0] f;
        f = {2'b01, cmd, arg, crcb};
        for (int i = 47; i >= 0; i--) begin
            DI = f[i];
            tick();
        end
        DI = 1'b0;
    endtask

    // Checks gap and R1 bits, then the cycle t+N_CR+9 request/busy state
    task automatic expect_r1(input string tag, input logic [7:0] r1, input logic rd, input logic inject);
        for (int k = 1; k <= N_CR; k++) begin
            tick();
            chk({tag, "_gap"}, 32'(DO), 32'd1);
        end
        for (int b = 7; b >= 0; b--) begin
            DI = inject;
            tick();
            chk({tag, "_r1bit"}, 32'(DO), 32'(r1[b]));
        end
        DI = 1'b0;
        tick();
        chk({tag, "_req"},  32'(RD_REQ), 32'(rd));
        chk({tag, "_busy"}, 32'(BUSY),   32'(rd));
    endtask

    // Full CMD17 transaction; abort_at >= 0 raises CS after that many data bits
    task automatic do_read(input string tag, input logic [31:0] arg, input int dly,
                           input logic [511:0] data, input int abort_at);
        logic [15:0] crc;
        logic [7:0]  tok;
        crc = crc_model(data);
        tok = 8'hFE;
        send_frame(6'd17, arg, 8'h01);
        expect_r1({tag, "_r1"}, 8'h00, 1'b1, 1'b0);
        chk({tag, "_adr"}, RD_ADR, arg);
        for (int k = 0; k < dly; k++) begin
            tick();
            chk({tag, "_reqhold"}, 32'(RD_REQ), 32'd1);
            chk({tag, "_waitdo"},  32'(DO),     32'd1);
        end
        RD_ACK  = 1'b1;
        RD_DATA = data;
        tick();
        RD_ACK  = 1'b0;
        RD_DATA = '0;
        chk({tag, "_reqdrop"}, 32'(RD_REQ), 32'd0);
        for (int b = 7; b >= 0; b--) begin
            chk({tag, "_token"}, 32'(DO), 32'(tok[b]));
            tick();
        end
        for (int i = 511; i >= 0; i--) begin
            if (abort_at >= 0 && (511 - i) == abort_at) begin
                CS = 1'b1;
                tick();
                chk({tag, "_abort_do"},   32'(DO),     32'd1);
                chk({tag, "_abort_busy"}, 32'(BUSY),   32'd0);
                chk({tag, "_abort_req"},  32'(RD_REQ), 32'd0);
                CS = 1'b0;
                tick();
                return;
            end
            chk({tag, "_data"}, 32'(DO), 32'(data[i]));
            tick();
        end
        for (int b = 15; b >= 0; b--) begin
            chk({tag, "_crc"}, 32'(DO), 32'(crc[b]));
            tick();
        end
        chk({tag, "_end_do"},   32'(DO),   32'd1);
        chk({tag, "_end_busy"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        logic [511:0] pat;
        n_total = 0;
        n_bad   = 0;
        RST     = 1'b1;
        CS      = 1'b1;
        DI      = 1'b0;
        RD_ACK  = 1'b0;
        RD_DATA = '0;
        repeat (3) tick();

        // Reset values
        chk("rst_do",    32'(DO),         32'd1);
        chk("rst_req",   32'(RD_REQ),     32'd0);
        chk("rst_adr",   RD_ADR,          32'd0);
        chk("rst_ready", 32'(CARD_READY), 32'd0);
        chk("rst_busy",  32'(BUSY),       32'd0);
        RST = 1'b0;
        tick();
        CS = 1'b0;
        repeat (2) tick();

        // CMD0 good CRC, then bad CRC
        send_frame(6'd0, 32'h0, 8'h95);
        expect_r1("cmd0", 8'h01, 1'b0, 1'b0);
        chk("cmd0_ready", 32'(CARD_READY), 32'd0);
        send_frame(6'd0, 32'h0, 8'h00);
        expect_r1("cmd0_badcrc", 8'h09, 1'b0, 1'b0);

        // CMD17 while idle: no data phase
        send_frame(6'd17, 32'h200, 8'h01);
        expect_r1("cmd17_idle", 8'h05, 1'b0, 1'b0);
        repeat (4) begin
            tick();
            chk("cmd17_idle_noreq", 32'(RD_REQ), 32'd0);
        end

        // CMD1 until ready
        send_frame(6'd1, 32'h0, 8'hF9);
        expect_r1("cmd1_a", 8'h01, 1'b0, 1'b0);
        send_frame(6'd1, 32'h0, 8'hF9);
        expect_r1("cmd1_b", 8'h01, 1'b0, 1'b0);
        send_frame(6'd1, 32'h0, 8'hF9);
        expect_r1("cmd1_c", 8'h01, 1'b0, 1'b0);
        chk("cmd1_c_ready", 32'(CARD_READY), 32'd0);
        send_frame(6'd1, 32'h0, 8'hF9);
        expect_r1("cmd1_d", 8'h00, 1'b0, 1'b0);
        chk("cmd1_d_ready", 32'(CARD_READY), 32'd1);

        // Zero block, late ack
        do_read("rd_zero", 32'h0000_0200, 5, 512'h0, -1);

        // Alternating A5/5A block, ack in the rising cycle of RD_REQ
        for (int i = 0; i < 64; i++) pat[511 - 8*i -: 8] = (i % 2 == 0) ? 8'hA5 : 8'h5A;
        do_read("rd_a55a", 32'h1234_5678, 0, pat, -1);

        // Deselect mid data, then a normal read
        for (int i = 0; i < 16; i++) pat[511 - 32*i -: 32] = 32'hDEAD_BEEF ^ (32'h0101_0101 * i);
        do_read("rd_abort", 32'h0000_0400, 1, pat, 100);
        do_read("rd_after", 32'h0000_0600, 2, pat, -1);

        // Deselect during WAIT_MEM, late ack must be ignored
        send_frame(6'd17, 32'h0000_0800, 8'h01);
        expect_r1("wm_r1", 8'h00, 1'b1, 1'b0);
        repeat (2) tick();
        chk("wm_req", 32'(RD_REQ), 32'd1);
        CS = 1'b1;
        tick();
        chk("wm_cs_req",  32'(RD_REQ), 32'd0);
        chk("wm_cs_busy", 32'(BUSY),   32'd0);
        chk("wm_cs_do",   32'(DO),     32'd1);
        CS      = 1'b0;
        RD_ACK  = 1'b1;
        RD_DATA = '1;
        tick();
        RD_ACK  = 1'b0;
        RD_DATA = '0;
        repeat (20) begin
            tick();
            chk("wm_late_do",   32'(DO),     32'd1);
            chk("wm_late_busy", 32'(BUSY),   32'd0);
            chk("wm_late_req",  32'(RD_REQ), 32'd0);
        end

        // Unsupported command with DI=1 during the response
        send_frame(6'd24, 32'h0000_1000, 8'h01);
        expect_r1("cmd24", 8'h04, 1'b0, 1'b1);
        repeat (60) begin
            tick();
            chk("cmd24_quiet", 32'(BUSY), 32'd0);
        end
        send_frame(6'd55, 32'h0, 8'h01);
        expect_r1("cmd55", 8'h04, 1'b0, 1'b0);
        send_frame(6'd0, 32'h0, 8'h95);
        expect_r1("cmd0_again", 8'h01, 1'b0, 1'b0);
        chk("cmd0_again_ready", 32'(CARD_READY), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
